// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - DVI 1.0 TMDS 8b/10b character encoder, two-stage pipeline
//
// Ports:
//   i_pixel_clk  - pixel clock; all state updates on the rising edge
//   i_reset_n    - asynchronous active-low reset
//   i_data[7:0]  - pixel component, used while i_de=1
//   i_ctrl[1:0]  - control bits {c1,c0}, used while i_de=0
//   i_de         - display enable (1 = video, 0 = control period)
//   o_tmds[9:0]  - encoded character, bit 0 transmitted first
//   o_disparity  - running disparity, signed 5-bit two's complement

module tmds_encoder (
    input  logic       i_pixel_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_de,
    output logic [9:0] o_tmds,
    output logic [4:0] o_disparity
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Stage 1 state
    logic       de_q,   de_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [8:0] q_m_q,  q_m_d;
    logic [3:0] n1_q,   n1_d;
    logic [3:0] n0_q,   n0_d;

    // Stage 2 state
    logic [9:0] tmds_q, tmds_d;
    logic [4:0] cnt_q,  cnt_d;

    logic [3:0] n1_data;
    logic       use_xnor;
    logic [4:0] n1_w;
    logic [4:0] n0_w;

    // Stage 1: transition minimisation and ones/zeros count of q_m[7:0]
    always_comb begin
        n1_data = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + {3'b000, i_data[i]};
        end
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !i_data[0]);

        q_m_d    = 9'd0;
        q_m_d[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ i_data[i]) : (q_m_d[i-1] ^ i_data[i]);
        end
        q_m_d[8] = ~use_xnor;

        n1_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_d = n1_d + {3'b000, q_m_d[i]};
        end
        n0_d   = 4'd8 - n1_d;
        de_d   = i_de;
        ctrl_d = i_ctrl;
    end

    // Counts widened to 5 bits so differences wrap correctly in two's complement
    assign n1_w = {1'b0, n1_q};
    assign n0_w = {1'b0, n0_q};

    // Stage 2: DC balancing against the running disparity
    always_comb begin
        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (!de_q) begin
            case (ctrl_q)
                2'b00:   tmds_d = CTRL_00;
                2'b01:   tmds_d = CTRL_01;
                2'b10:   tmds_d = CTRL_10;
                default: tmds_d = CTRL_11;
            endcase
            cnt_d = 5'd0;
        end else if ((cnt_q == 5'd0) || (n1_q == n0_q)) begin
            if (q_m_q[8]) begin
                tmds_d = {1'b0, 1'b1, q_m_q[7:0]};
                cnt_d  = cnt_q + n1_w - n0_w;
            end else begin
                tmds_d = {1'b1, 1'b0, ~q_m_q[7:0]};
                cnt_d  = cnt_q + n0_w - n1_w;
            end
        end else if ((!cnt_q[4] && (n1_q > n0_q)) || (cnt_q[4] && (n0_q > n1_q))) begin
            // Disparity already leans the same way as this word: invert to pull back
            tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_d  = cnt_q + {3'b000, q_m_q[8], 1'b0} + n0_w - n1_w;
        end else begin
            tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_d  = cnt_q - {3'b000, ~q_m_q[8], 1'b0} + n1_w - n0_w;
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            q_m_q  <= 9'd0;
            n1_q   <= 4'd0;
            n0_q   <= 4'd0;
            tmds_q <= CTRL_00;
            cnt_q  <= 5'd0;
        end else begin
            de_q   <= de_d;
            ctrl_q <= ctrl_d;
            q_m_q  <= q_m_d;
            n1_q   <= n1_d;
            n0_q   <= n0_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_tmds      = tmds_q;
    assign o_disparity = cnt_q;

endmodule
